// File: rtl/icache_pkg.sv
// ============================================================================
// Module      : icache_pkg
// Description : Shared types and constants for the direct-mapped I-cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_pkg;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W = 32 - 3 - ICACHE_IDX_W;
    localparam int MISS_CNT_W   = 16;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH0 = 2'd1,
        FETCH1 = 2'd2
    } icache_state_t;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic                    blkoff;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t [1:0]             data;
    } icache_frame_t;

    function automatic logic [MISS_CNT_W-1:0] sat_inc(input logic [MISS_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/icache_if.sv
// ============================================================================
// Module      : icache_if
// Description : Fetch-port and memory-port bundle of the instruction cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface icache_if
    import icache_pkg::*;
#(
    parameter int PC_BITS = 32
);
    logic                  imemREN;
    logic [PC_BITS-1:0]    imemaddr;
    logic                  ihit;
    word_t                 imemload;
    logic                  iREN;
    logic [PC_BITS-1:0]    iaddr;
    logic                  iwait;
    word_t                 iload;
    logic [MISS_CNT_W-1:0] miss_count;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr, miss_count
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr, miss_count
    );
endinterface

`default_nettype wire

// File: rtl/icache.sv
// ============================================================================
// Module      : icache
// Description : Direct-mapped read-only I-cache, 2-word blocks, miss counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache
    import icache_pkg::*;
#(
    parameter int SETS    = ICACHE_SETS,
    parameter int PC_BITS = 32
) (
    input  wire logic CLK,
    input  wire logic nRST,
    icache_if.slave   bus
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = PC_BITS - 3 - IDX_W;

    icache_state_t           state_q, state_d;
    logic [TAG_W+IDX_W-1:0]  fill_q, fill_d;
    word_t                   word0_q, word0_d;
    logic [MISS_CNT_W-1:0]   miss_count_q, miss_count_d;
    logic                    iren_q, iren_d;
    logic [PC_BITS-1:0]      iaddr_q, iaddr_d;
    logic [SETS-1:0]         valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q  [SETS];
    word_t                   data_q [SETS][2];

    logic [TAG_W-1:0]        w_tag;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_blk;
    logic                    w_hit;
    logic [TAG_W-1:0]        w_fill_tag;
    logic [IDX_W-1:0]        w_fill_idx;
    logic                    w_frame_we;
    logic [1:0]              w_unused_bytoff;

    assign w_tag           = bus.imemaddr[PC_BITS-1:3+IDX_W];
    assign w_idx           = bus.imemaddr[2+IDX_W:3];
    assign w_blk           = bus.imemaddr[2];
    assign w_unused_bytoff = bus.imemaddr[1:0];
    assign w_fill_tag      = fill_q[TAG_W+IDX_W-1:IDX_W];
    assign w_fill_idx      = fill_q[IDX_W-1:0];

    // Lookups are only honoured in IDLE: there is no hit-under-miss.
    assign w_hit = (state_q == IDLE) && bus.imemREN && valid_q[w_idx]
                   && (tag_q[w_idx] == w_tag);

    assign bus.ihit       = w_hit;
    assign bus.imemload   = w_hit ? data_q[w_idx][w_blk] : '0;
    assign bus.iREN       = iren_q;
    assign bus.iaddr      = iaddr_q;
    assign bus.miss_count = miss_count_q;

    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        word0_d      = word0_q;
        miss_count_d = miss_count_q;
        iren_d       = iren_q;
        iaddr_d      = iaddr_q;
        valid_d      = valid_q;
        w_frame_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.imemREN && !w_hit) begin
                    fill_d       = {w_tag, w_idx};
                    miss_count_d = sat_inc(miss_count_q);
                    state_d      = FETCH0;
                    iren_d       = 1'b1;
                    iaddr_d      = {w_tag, w_idx, 1'b0, 2'b00};
                end
            end
            FETCH0: begin
                if (!bus.iwait) begin
                    word0_d = bus.iload;
                    state_d = FETCH1;
                    iaddr_d = {fill_q, 1'b1, 2'b00};
                end
            end
            FETCH1: begin
                // Second word arrives: the whole block is installed at once.
                if (!bus.iwait) begin
                    w_frame_we          = 1'b1;
                    valid_d[w_fill_idx] = 1'b1;
                    state_d             = IDLE;
                    iren_d              = 1'b0;
                    iaddr_d             = '0;
                end
            end
            default: begin
                state_d = IDLE;
                iren_d  = 1'b0;
                iaddr_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            fill_q       <= '0;
            word0_q      <= '0;
            miss_count_q <= '0;
            iren_q       <= 1'b0;
            iaddr_q      <= '0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            word0_q      <= word0_d;
            miss_count_q <= miss_count_d;
            iren_q       <= iren_d;
            iaddr_q      <= iaddr_d;
            valid_q      <= valid_d;
        end
    end

    // Tag/data storage carries no reset; valid bits alone qualify it.
    always_ff @(posedge CLK) begin
        if (w_frame_we) begin
            tag_q[w_fill_idx]     <= w_fill_tag;
            data_q[w_fill_idx][0] <= word0_q;
            data_q[w_fill_idx][1] <= bus.iload;
        end
    end

endmodule

`default_nettype wire
